// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: character-cell text buffer write controller (CLEAR/IDLE/WRITE/FILL).
// Optional macro TXT_BACKSPACE_EN enables 0x08 as a destructive backspace.
module text_buffer_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int COLS_LOG2  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  clr_req,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [ADDR_WIDTH-1:0] cursor,
    output logic                  busy
);
    typedef enum logic [1:0] {CLEAR, IDLE, WRITE, FILL} state_t;
    localparam logic [DATA_WIDTH-1:0] SP = DATA_WIDTH'('h20);
    localparam logic [DATA_WIDTH-1:0] LF = DATA_WIDTH'('h0A);
    localparam logic [DATA_WIDTH-1:0] CR = DATA_WIDTH'('h0D);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cursor_q, cursor_d, ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic                  ram_we_q, ram_we_d, clr_pending_q, clr_pending_d;
    logic                  accept, line_end, go_clear;
`ifdef TXT_BACKSPACE_EN
    localparam logic [DATA_WIDTH-1:0] BS = DATA_WIDTH'('h08);
    logic bs_q, bs_d;
`endif
    assign rx_ready = (state_q == IDLE) && !clr_req && !clr_pending_q;
    assign accept   = rx_valid && rx_ready;
    assign line_end = &cursor_q[COLS_LOG2-1:0];
    assign go_clear = clr_pending_q || clr_req;
    assign ram_we   = ram_we_q;
    assign ram_din  = ram_din_q;
    assign ram_addr = ram_addr_q;
    assign cursor   = cursor_q;
    assign busy     = state_q != IDLE;
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        clr_cnt_d     = clr_cnt_q;
        clr_pending_d = clr_pending_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
`ifdef TXT_BACKSPACE_EN
        bs_d          = bs_q;
`endif
        case (state_q)
            CLEAR: begin
                // top counter bit marks that the last cell has been issued
                if (clr_cnt_q[ADDR_WIDTH]) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = clr_cnt_q[ADDR_WIDTH-1:0];
                    ram_din_d  = SP;
                    clr_cnt_d  = clr_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (accept) begin
                    if (rx_data == LF) begin
                        state_d    = FILL;
                        ram_we_d   = 1'b1;
                        ram_addr_d = cursor_q;
                        ram_din_d  = SP;
                    end
`ifdef TXT_BACKSPACE_EN
                    else if (rx_data == BS) begin
                        if (cursor_q[COLS_LOG2-1:0] != '0) begin
                            state_d    = WRITE;
                            cursor_d   = cursor_q - 1'b1;
                            ram_we_d   = 1'b1;
                            ram_addr_d = cursor_q - 1'b1;
                            ram_din_d  = SP;
                            bs_d       = 1'b1;
                        end
                    end
`endif
                    else if (rx_data != CR) begin
                        state_d    = WRITE;
                        ram_we_d   = 1'b1;
                        ram_addr_d = cursor_q;
                        ram_din_d  = rx_data;
`ifdef TXT_BACKSPACE_EN
                        bs_d       = 1'b0;
`endif
                    end
                end
            end
            WRITE: begin
                cursor_d      = cursor_q + 1'b1;
`ifdef TXT_BACKSPACE_EN
                if (bs_q) cursor_d = cursor_q;
`endif
                clr_pending_d = 1'b0;
                state_d       = go_clear ? CLEAR : IDLE;
                clr_cnt_d     = '0;
            end
            FILL: begin
                cursor_d = cursor_q + 1'b1;
                if (!line_end) begin
                    ram_we_d      = 1'b1;
                    ram_addr_d    = cursor_q + 1'b1;
                    clr_pending_d = go_clear;
                end else begin
                    clr_pending_d = 1'b0;
                    state_d       = go_clear ? CLEAR : IDLE;
                    clr_cnt_d     = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= CLEAR;
            cursor_q      <= '0;
            clr_cnt_q     <= '0;
            clr_pending_q <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_din_q     <= '0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            clr_cnt_q     <= clr_cnt_d;
            clr_pending_q <= clr_pending_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
        end
    end
`ifdef TXT_BACKSPACE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bs_q <= 1'b0;
        else       bs_q <= bs_d;
    end
`endif
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: directed self-checking bench for text_buffer_ctrl.
// RAM writes are logged at the falling edge and compared against hand-computed sequences.
module tb_text_buffer_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       clr_req = 1'b0;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [10:0] ram_addr;
    logic [10:0] cursor;
    logic       busy;
    int checks = 0;
    int errors = 0;
    int idle_we = 0;
    int wa[$];
    int wd[$];

    text_buffer_ctrl dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .clr_req(clr_req), .ram_we(ram_we), .ram_din(ram_din),
        .ram_addr(ram_addr), .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            wa.push_back(int'(ram_addr));
            wd.push_back(int'(ram_din));
            if (!busy) idle_we++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy && n < lim) begin
            step();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $error("FAIL wait_idle timeout observed busy=1 expected busy=0");
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        wait_idle(5000);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    function automatic int sweep_bad(input int base);
        int bad = 0;
        for (int i = 0; i < 2048; i++)
            if (base + i >= wa.size() || wa[base+i] != i || wd[base+i] != 'h20) bad++;
        return bad;
    endfunction

    initial begin
        // reset state
        step();
        step();
        chk("rst_busy", busy, 1);
        chk("rst_ready", rx_ready, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        clear_log();
        reset = 1'b0;
        wait_idle(3000);
        chk("init_count", wa.size(), 2048);
        chk("init_sweep_bad", sweep_bad(0), 0);
        chk("init_cursor", cursor, 0);
        chk("init_ready", rx_ready, 1);
        chk("init_busy", busy, 0);

        // printable bytes
        clear_log();
        send(8'h41);
        send(8'h42);
        chk("ab_count", wa.size(), 2);
        chk("a_addr", wa[0], 0);
        chk("a_data", wd[0], 'h41);
        chk("b_addr", wa[1], 1);
        chk("b_data", wd[1], 'h42);
        chk("ab_cursor", cursor, 2);

        // carriage return at cursor 5
        send(8'h43);
        send(8'h44);
        send(8'h45);
        chk("c5_cursor", cursor, 5);
        clear_log();
        send(8'h0D);
        step();
        step();
        chk("cr_nowrite", wa.size(), 0);
        chk("cr_cursor", cursor, 5);
        chk("cr_busy", busy, 0);

        // line feed at col 62
        for (int i = 0; i < 57; i++) send(8'h61);
        chk("c3e_cursor", cursor, 'h3E);
        clear_log();
        send(8'h0A);
        chk("lf62_count", wa.size(), 2);
        chk("lf62_a0", wa[0], 'h3E);
        chk("lf62_d0", wd[0], 'h20);
        chk("lf62_a1", wa[1], 'h3F);
        chk("lf62_d1", wd[1], 'h20);
        chk("lf62_cursor", cursor, 'h40);

        // full-line fill with clear request on its 10th cycle
        clear_log();
        rx_data  = 8'h0A;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("fill10_busy", busy, 1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wait_idle(5000);
        chk("fillclr_count", wa.size(), 64 + 2048);
        begin
            int bad = 0;
            for (int i = 0; i < 64; i++) if (wa[i] != 'h40 + i || wd[i] != 'h20) bad++;
            chk("fill_bad", bad, 0);
        end
        chk("fillclr_sweep_bad", sweep_bad(64), 0);
        chk("fillclr_cursor", cursor, 0);

        // clear request beats a simultaneous byte, then reset mid-clear
        clear_log();
        rx_data  = 8'h51;
        rx_valid = 1'b1;
        clr_req  = 1'b1;
        #1;
        chk("clr_rx_ready", rx_ready, 0);
        step();
        rx_valid = 1'b0;
        clr_req  = 1'b0;
        chk("clr_busy", busy, 1);
        for (int i = 0; i < 100; i++) step();
        chk("clr_started", int'(wa.size() > 50), 1);
        chk("clr_first_addr", wa[0], 0);
        chk("clr_first_data", wd[0], 'h20);
        reset = 1'b1;
        #1;
        chk("midclr_we", ram_we, 0);
        chk("midclr_busy", busy, 1);
        clear_log();
        step();
        step();
        reset = 1'b0;
        wait_idle(3000);
        chk("restart_count", wa.size(), 2048);
        chk("restart_sweep_bad", sweep_bad(0), 0);
        chk("restart_cursor", cursor, 0);

        // wrap from the last cell
        for (int i = 0; i < 2047; i++) send(8'h62);
        chk("c2047_cursor", cursor, 2047);
        clear_log();
        send(8'h5A);
        chk("wrap_count", wa.size(), 1);
        chk("wrap_addr", wa[0], 2047);
        chk("wrap_data", wd[0], 'h5A);
        chk("wrap_cursor", cursor, 0);

        // 0x0A at col 0 blanks a full line
        clear_log();
        send(8'h0A);
        chk("lf0_count", wa.size(), 64);
        chk("lf0_first", wa[0], 0);
        chk("lf0_last", wa[63], 63);
        chk("lf0_cursor", cursor, 'h40);
        for (int i = 0; i < 5; i++) send(8'h63);
        chk("c45_cursor", cursor, 'h45);
        clear_log();
        send(8'h08);
`ifdef TXT_BACKSPACE_EN
        chk("bs_count", wa.size(), 1);
        chk("bs_addr", wa[0], 'h44);
        chk("bs_data", wd[0], 'h20);
        chk("bs_cursor", cursor, 'h44);
        send(8'h0A);
        chk("c80_cursor", cursor, 'h80);
        clear_log();
        send(8'h08);
        step();
        chk("bs0_count", wa.size(), 0);
        chk("bs0_cursor", cursor, 'h80);
`else
        chk("bs_count", wa.size(), 1);
        chk("bs_addr", wa[0], 'h45);
        chk("bs_data", wd[0], 'h08);
        chk("bs_cursor", cursor, 'h46);
`endif
        chk("idle_we", idle_we, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
